// File: rtl/mem_port_scheduler_pkg.sv
// rtl/mem_port_scheduler_pkg.sv - shared types and constants for the memory port scheduler
package mem_port_scheduler_pkg;

    localparam int MEM_REQ_PER_CORE          = 2;
    localparam int ICACHE_ACCESS_ID_BIT      = 6;
    localparam int MEM_SCHED_MAX_OUTSTANDING = 16;
    localparam int MEM_SCHED_STARVE_LIMIT    = 8;

    localparam int ACCESS_ID_W = 8;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;

    typedef struct packed {
        logic                   vld;
        logic [ACCESS_ID_W-1:0] access_id;
        logic [ADDR_W-1:0]      addr;
        logic [DATA_W-1:0]      data;
    } request_t;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_e;

endpackage

// File: rtl/mem_port_scheduler_outstanding_counter.sv
// rtl/mem_port_scheduler_outstanding_counter.sv - saturating in-flight counter with sticky underflow flag
module mem_port_scheduler_outstanding_counter #(
    parameter int MAX = 16,
    parameter int CW  = $clog2(MAX) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          err
);

    logic          dec_eff;
    logic          inc_eff;
    logic [CW-1:0] count_d;

    // A decrement at zero is an orphan response: it never moves the count.
    assign dec_eff = dec && (count != '0);
    assign inc_eff = inc && ((count != CW'(MAX)) || dec_eff);
    assign full    = (count == CW'(MAX));

    // Next count: simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count;
        if (inc_eff && !dec_eff) begin
            count_d = count + CW'(1);
        end else if (dec_eff && !inc_eff) begin
            count_d = count - CW'(1);
        end
    end

    // Count register and sticky underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            count <= count_d;
            if (dec && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - arbitrates icache and lsu onto one memory request port
module mem_port_scheduler
    import mem_port_scheduler_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MEM_SCHED_MAX_OUTSTANDING,
    parameter int STARVE_LIMIT    = MEM_SCHED_STARVE_LIMIT,
    parameter int ICACHE_ID_BIT   = ICACHE_ACCESS_ID_BIT,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  request_t                    icache_mem_req,
    input  request_t                    lsu_mem_req,
    output logic [MEM_REQ_PER_CORE-1:0] grant,
    output request_t                    mem_req,
    input  logic                        mem_req_ready,
    input  request_t                    mem_rsp,
    output request_t                    icache_mem_rsp,
    output request_t                    lsu_mem_rsp,
    output logic [CNT_W-1:0]            outstanding_icache,
    output logic [CNT_W-1:0]            outstanding_lsu,
    output logic                        rsp_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    stage_e        state_q;
    stage_e        state_d;
    logic [SW-1:0] starve_cnt;
    logic          stage_ok;
    logic          rsp_icache;
    logic          rsp_lsu;
    logic          full_icache;
    logic          full_lsu;
    logic          err_icache;
    logic          err_lsu;
    logic          elig_icache;
    logic          elig_lsu;
    logic          starved;

    assign rsp_icache  = mem_rsp.vld && mem_rsp.access_id[ICACHE_ID_BIT];
    assign rsp_lsu     = mem_rsp.vld && !mem_rsp.access_id[ICACHE_ID_BIT];
    assign stage_ok    = (state_q == STAGE_EMPTY) || mem_req_ready;
    // A response arriving this cycle frees a credit in time for a same-cycle grant.
    assign elig_icache = icache_mem_req.vld && (!full_icache || rsp_icache) && stage_ok;
    assign elig_lsu    = lsu_mem_req.vld && (!full_lsu || rsp_lsu) && stage_ok;
    assign starved     = (starve_cnt >= SW'(STARVE_LIMIT));
    assign rsp_err     = err_icache || err_lsu;

    // Fixed priority to icache, overridden once the lsu has waited long enough.
    always_comb begin
        grant = '0;
        if (elig_lsu && (!elig_icache || starved)) begin
            grant[1] = 1'b1;
        end else if (elig_icache) begin
            grant[0] = 1'b1;
        end
    end

    // Output stage next state: refilled on any grant, drained on ready without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STAGE_EMPTY: if (grant != '0) state_d = STAGE_FULL;
            STAGE_FULL:  if (mem_req_ready && (grant == '0)) state_d = STAGE_EMPTY;
            default:     state_d = STAGE_EMPTY;
        endcase
    end

    // Output stage state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STAGE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage payload: load the winner, clear once memory has taken it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req <= '0;
        end else if (grant[0]) begin
            mem_req <= icache_mem_req;
        end else if (grant[1]) begin
            mem_req <= lsu_mem_req;
        end else if ((state_q == STAGE_FULL) && mem_req_ready) begin
            mem_req <= '0;
        end
    end

    // Count consecutive cycles the lsu waits while requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!lsu_mem_req.vld || grant[1]) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Route each response to its owner as a one-cycle registered pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icache_mem_rsp <= '0;
            lsu_mem_rsp    <= '0;
        end else begin
            icache_mem_rsp <= rsp_icache ? mem_rsp : '0;
            lsu_mem_rsp    <= rsp_lsu ? mem_rsp : '0;
        end
    end

    mem_port_scheduler_outstanding_counter #(
        .MAX (MAX_OUTSTANDING),
        .CW  (CNT_W)
    ) u_cnt_icache (
        .clk   (clk),
        .reset (reset),
        .inc   (grant[0]),
        .dec   (rsp_icache),
        .count (outstanding_icache),
        .full  (full_icache),
        .err   (err_icache)
    );

    mem_port_scheduler_outstanding_counter #(
        .MAX (MAX_OUTSTANDING),
        .CW  (CNT_W)
    ) u_cnt_lsu (
        .clk   (clk),
        .reset (reset),
        .inc   (grant[1]),
        .dec   (rsp_lsu),
        .count (outstanding_lsu),
        .full  (full_lsu),
        .err   (err_lsu)
    );

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - self-checking bench for mem_port_scheduler
module tb_mem_port_scheduler;
    import mem_port_scheduler_pkg::*;

    localparam int MAXO = 16;
    localparam int SL   = 8;
    localparam int IB   = 6;

    logic       clk = 1'b0;
    logic       reset;
    request_t   ireq, lreq, mem_req, mem_rsp, irsp, lrsp;
    logic [1:0] grant;
    logic       ready;
    logic [4:0] oi, ol;
    logic       rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept as plain integers and flags.
    bit         m_full;
    request_t   m_req, m_irsp, m_lrsp;
    int         m_cnt[2];
    int         m_starve;
    bit         m_err;
    logic [1:0] m_g;

    mem_port_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .icache_mem_req     (ireq),
        .lsu_mem_req        (lreq),
        .grant              (grant),
        .mem_req            (mem_req),
        .mem_req_ready      (ready),
        .mem_rsp            (mem_rsp),
        .icache_mem_rsp     (irsp),
        .lsu_mem_rsp        (lrsp),
        .outstanding_icache (oi),
        .outstanding_lsu    (ol),
        .rsp_err            (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic request_t mk(logic v, logic [7:0] id, logic [31:0] a, logic [31:0] d);
        request_t r;
        r.vld       = v;
        r.access_id = id;
        r.addr      = a;
        r.data      = d;
        return r;
    endfunction

    function automatic void model_reset();
        m_full   = 1'b0;
        m_req    = '0;
        m_irsp   = '0;
        m_lrsp   = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_starve = 0;
        m_err    = 1'b0;
        m_g      = 2'b00;
    endfunction

    function automatic logic [1:0] model_grant();
        bit ok, ri, rl, e0, e1;
        ok = !m_full || ready;
        ri = mem_rsp.vld && mem_rsp.access_id[IB];
        rl = mem_rsp.vld && !mem_rsp.access_id[IB];
        e0 = ireq.vld && ok && (m_cnt[0] < MAXO || ri);
        e1 = lreq.vld && ok && (m_cnt[1] < MAXO || rl);
        if (e1 && (!e0 || m_starve >= SL)) return 2'b10;
        if (e0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_step(logic [1:0] g);
        bit rsp_to[2];
        rsp_to[0] = mem_rsp.vld && mem_rsp.access_id[IB];
        rsp_to[1] = mem_rsp.vld && !mem_rsp.access_id[IB];
        if (g[0]) m_req = ireq;
        else if (g[1]) m_req = lreq;
        else if (m_full && ready) m_req = '0;
        m_full = (g != 2'b00) || (m_full && !ready);
        for (int i = 0; i < 2; i++) begin
            if (rsp_to[i]) begin
                if (m_cnt[i] == 0) m_err = 1'b1;
                else m_cnt[i] = m_cnt[i] - 1;
            end
            if (g[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        if (!lreq.vld || g[1]) m_starve = 0;
        else if (m_starve < SL) m_starve = m_starve + 1;
        m_irsp = rsp_to[0] ? mem_rsp : '0;
        m_lrsp = rsp_to[1] ? mem_rsp : '0;
    endfunction

    task automatic check_all(string tag);
        chk({tag, ".grant"}, 96'(grant), 96'(m_g));
        chk({tag, ".mem_req"}, 96'(mem_req), 96'(m_req));
        chk({tag, ".icache_rsp"}, 96'(irsp), 96'(m_irsp));
        chk({tag, ".lsu_rsp"}, 96'(lrsp), 96'(m_lrsp));
        chk({tag, ".out_icache"}, 96'(oi), 96'(m_cnt[0]));
        chk({tag, ".out_lsu"}, 96'(ol), 96'(m_cnt[1]));
        chk({tag, ".rsp_err"}, 96'(rsp_err), 96'(m_err));
    endtask

    // One clock: compare everything at the falling edge, advance the model, return just after the rising edge.
    task automatic tick(string tag);
        @(negedge clk);
        m_g = model_grant();
        check_all(tag);
        model_step(m_g);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ireq    = '0;
        lreq    = '0;
        mem_rsp = '0;
        ready   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit         iv;
        bit         rdy;
        logic [31:0] addr;
        logic [1:0] eg;
        bit         emv;
        int         eoi;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int lsu_n;
        int k;

        // Issue three icache requests, then stall the output stage and release it.
        tbl[0]  = '{1'b1, 1'b1, 32'h100, 2'b01, 1'b0, 0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h104, 2'b01, 1'b1, 1, 32'h100};
        tbl[2]  = '{1'b1, 1'b1, 32'h108, 2'b01, 1'b1, 2, 32'h104};
        tbl[3]  = '{1'b0, 1'b1, 32'h0,   2'b00, 1'b1, 3, 32'h108};
        tbl[4]  = '{1'b0, 1'b1, 32'h0,   2'b00, 1'b0, 3, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h200, 2'b01, 1'b0, 3, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h204, 2'b00, 1'b1, 4, 32'h200};
        tbl[7]  = '{1'b1, 1'b0, 32'h204, 2'b00, 1'b1, 4, 32'h200};
        tbl[8]  = '{1'b1, 1'b0, 32'h204, 2'b00, 1'b1, 4, 32'h200};
        tbl[9]  = '{1'b1, 1'b0, 32'h204, 2'b00, 1'b1, 4, 32'h200};
        tbl[10] = '{1'b1, 1'b1, 32'h204, 2'b01, 1'b1, 4, 32'h200};
        tbl[11] = '{1'b0, 1'b1, 32'h0,   2'b00, 1'b1, 5, 32'h204};
        tbl[12] = '{1'b0, 1'b1, 32'h0,   2'b00, 1'b0, 5, 32'h0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            ireq  = mk(tbl[i].iv, 8'h41, tbl[i].addr, 32'hA000 + i);
            ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d.grant", i), 96'(grant), 96'(tbl[i].eg));
            chk($sformatf("tbl%0d.mvld", i), 96'(mem_req.vld), 96'(tbl[i].emv));
            chk($sformatf("tbl%0d.maddr", i), 96'(mem_req.addr), 96'(tbl[i].eaddr));
            chk($sformatf("tbl%0d.oi", i), 96'(oi), 96'(tbl[i].eoi));
            tick($sformatf("tbl%0d", i));
        end

        // Both requesting: lsu wins every ninth cycle.
        do_reset();
        lsu_n = 0;
        for (int i = 0; i < 18; i++) begin
            ireq  = mk(1'b1, 8'h40, 32'h1000 + i, 32'h0);
            lreq  = mk(1'b1, 8'h01, 32'h2000 + lsu_n, 32'h0);
            ready = 1'b1;
            #1;
            chk($sformatf("starve%0d", i), 96'(grant), (i == 8 || i == 17) ? 96'd2 : 96'd1);
            tick("starve");
            if (m_g[1]) lsu_n++;
        end

        // lsu credits exhausted, then a same-cycle response reopens a slot.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lreq = mk(1'b1, 8'h02, 32'h3000 + i, 32'h0);
            tick("lsu_fill");
        end
        lreq = mk(1'b1, 8'h02, 32'h3100, 32'h0);
        #1;
        chk("lsu_full_nogrant", 96'(grant), 96'd0);
        tick("lsu_full");
        mem_rsp = mk(1'b1, 8'h05, 32'h3000, 32'hBEEF);
        #1;
        chk("lsu_full_rsp_grant", 96'(grant), 96'd2);
        tick("lsu_full_rsp");
        lreq    = '0;
        mem_rsp = '0;
        #1;
        chk("lsu_full_count", 96'(ol), 96'd16);
        chk("lsu_rsp_vld", 96'(lrsp.vld), 96'd1);
        tick("lsu_after");

        // Orphan icache response: forwarded, count pinned at 0, sticky error.
        do_reset();
        mem_rsp = mk(1'b1, 8'h40, 32'hABC, 32'h1234);
        tick("orphan");
        mem_rsp = '0;
        #1;
        chk("orphan_rsp_vld", 96'(irsp.vld), 96'd1);
        chk("orphan_rsp_addr", 96'(irsp.addr), 96'h0ABC);
        chk("orphan_count", 96'(oi), 96'd0);
        chk("orphan_err", 96'(rsp_err), 96'd1);
        tick("orphan1");
        chk("orphan_rsp_pulse", 96'(irsp.vld), 96'd0);
        chk("orphan_err_sticky", 96'(rsp_err), 96'd1);
        tick("orphan2");

        // Asynchronous reset with a full stage and counts 5/3.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ireq = mk(i < 5, 8'h40, 32'h4000 + i, 32'h0);
            lreq = mk(1'b1, 8'h03, 32'h5000 + (i < 5 ? 0 : i - 5), 32'h0);
            tick("pre_reset");
        end
        clear_inputs();
        #1;
        chk("pre_reset_oi", 96'(oi), 96'd5);
        chk("pre_reset_ol", 96'(ol), 96'd3);
        chk("pre_reset_mvld", 96'(mem_req.vld), 96'd1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_mvld", 96'(mem_req.vld), 96'd0);
        check_all("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if (!ireq.vld && $urandom_range(0, 99) < 60)
                ireq = mk(1'b1, 8'($urandom), $urandom, $urandom);
            if (!lreq.vld && $urandom_range(0, 99) < 50)
                lreq = mk(1'b1, 8'($urandom), $urandom, $urandom);
            ready   = ($urandom_range(0, 99) < 70);
            mem_rsp = '0;
            if ($urandom_range(0, 99) < 45) begin
                k = $urandom_range(0, 1);
                if (m_cnt[k] > 0 || $urandom_range(0, 99) < 3) begin
                    mem_rsp = mk(1'b1, 8'($urandom), $urandom, $urandom);
                    mem_rsp.access_id[IB] = (k == 0);
                end
            end
            tick("rand");
            if (m_g[0]) ireq = '0;
            if (m_g[1]) lreq = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Shares the single core-to-memory request port between the icache (requester 0) and the vector load/store unit (requester 1).
- Routes memory responses back to the owning requester and tracks outstanding requests per requester.
- Arbitration is fixed priority with starvation protection, gated by per-requester outstanding credits and a downstream ready handshake.
- Sits at the core boundary, between the icache, the load/store unit and the memory interconnect.

Parameters:
MAX_OUTSTANDING, 16, max in-flight requests per requester (power of two, ≥2)
STARVE_LIMIT, 8, consecutive denied cycles of requester 1 before forced promotion
ICACHE_ID_BIT, 6, access_id bit that marks an icache response (1 = icache)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
icache_mem_req  input  request_t  icache request; held with .vld until granted
lsu_mem_req  input  request_t  load/store unit request; held with .vld until granted
grant  output  2  one-hot; bit0 icache, bit1 lsu; combinational, same cycle as acceptance
mem_req  output  request_t  registered request to memory
mem_req_ready  input  1  memory accepts mem_req this cycle when mem_req.vld=1
mem_rsp  input  request_t  memory response, valid on .vld
icache_mem_rsp  output  request_t  registered response to icache
lsu_mem_rsp  output  request_t  registered response to load/store unit
outstanding_icache  output  $clog2(MAX_OUTSTANDING)+1  in-flight count, icache
outstanding_lsu  output  $clog2(MAX_OUTSTANDING)+1  in-flight count, lsu
rsp_err  output  1  sticky; a response arrived for a requester with count 0

Behaviour:
- Reset:
  - All outputs are 0: mem_req, both rsp outputs, counters, rsp_err.
  - Output stage is EMPTY and the starvation counter is 0.
  - Reset is asynchronous and may assert mid-operation; any in-flight or held request is dropped and the counters clear.
- Output stage FSM:
  - EMPTY: mem_req.vld=0.
  - FULL: mem_req holds a request.
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY when mem_req_ready=1 and no new grant.
  - FULL -> FULL with new contents when ready=1 and a grant happens in the same cycle; this gives back-to-back issue at 1 request/cycle.
  - FULL with ready=0: mem_req is held stable and no grant is issued.
- Grant eligibility: requester i is eligible when its .vld=1, its outstanding count < MAX_OUTSTANDING, and (stage EMPTY or mem_req_ready=1).
- Arbitration:
  - Icache wins if eligible, unless starve_cnt ≥ STARVE_LIMIT and lsu is eligible; then lsu wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle lsu.vld=1 and lsu is not granted.
  - starve_cnt clears on an lsu grant or when lsu.vld=0.
- Latency: a request granted in cycle N appears on mem_req in cycle N+1.
- Grant: at most one bit set per cycle; no grant when no requester is eligible.
- Counters:
  - Increment on grant; decrement on a response routed to that requester.
  - Grant and response for the same requester in the same cycle leave the count unchanged.
  - A requester at MAX_OUTSTANDING becomes eligible again in the same cycle a response for it arrives.
- Response routing:
  - mem_rsp.vld with access_id[ICACHE_ID_BIT]=1 goes to icache_mem_rsp; =0 goes to lsu_mem_rsp.
  - The routed output is registered, 1-cycle latency.
  - .vld on each response output is a one-cycle pulse, cleared the next cycle unless another response arrives; the payload is the full mem_rsp.
- Underflow: a response for a requester with count 0 is still forwarded, the count stays 0, and rsp_err sets until reset.
- Responses are never back-pressured and are accepted every cycle.

Decomposition:
- Shared package: request_t (existing); MEM_REQ_PER_CORE; new constants ICACHE_ACCESS_ID_BIT and MEM_SCHED_MAX_OUTSTANDING.
- Sub-module outstanding_counter: saturating up/down counter with inc, dec, full and underflow-error outputs; instantiated twice.
- Arbitration and the output-stage FSM stay in the top module.

Test Plan:
- Only icache valid, 3 requests, ready=1 -> grant=01 on cycles 0,1,2; mem_req.vld on cycles 1,2,3; outstanding_icache=3.
- Both valid continuously, STARVE_LIMIT=8 -> 8 icache grants, then grant=10 on the 9th cycle; starve_cnt returns to 0.
- Stage FULL, ready=0 for 4 cycles -> mem_req stable, grant=00; ready=1 -> the held request is consumed and a new grant is issued that same cycle.
- lsu at 16 outstanding -> no lsu grant; a response with access_id[6]=0 plus lsu.vld in the same cycle -> grant=10 and count stays 16.
- Response with access_id[6]=1 while outstanding_icache=0 -> icache_mem_rsp.vld pulses 1 cycle later, count stays 0, rsp_err=1 and sticky.
- Reset asserted while stage FULL with counts 5/3 -> mem_req.vld drops immediately; counters, responses and rsp_err are all 0.
